// File: rtl/bank_pkg.sv
// rtl/bank_pkg.sv - default bank geometry and the default-size stage-1 request record
package bank_pkg;

    localparam int N_DEF      = 5;
    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 8;
    localparam int IDX_W_DEF  = (N_DEF > 1) ? $clog2(N_DEF) : 1;

    typedef struct packed {
        logic [IDX_W_DEF-1:0]  idx;
        logic                  we;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
        logic                  valid;
    } bank_req_t;

endpackage

// File: rtl/onehot_enc.sv
// rtl/onehot_enc.sv - one-hot to index encoder with any/multi-hot flags
module onehot_enc #(
    parameter int N     = 5,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             any,
    output logic             multi
);

    always_comb begin
        idx   = '0;
        any   = 1'b0;
        multi = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (onehot[i]) begin
                if (any) multi = 1'b1;
                any = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/bank_responder.sv
// rtl/bank_responder.sv - two-stage single-bank responder for N requesters
module bank_responder
    import bank_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N-1:0]        grant,
    input  logic [N-1:0]        req_we,
    input  logic [N*ADDR_W-1:0] req_addr,
    input  logic [N*DATA_W-1:0] req_wdata,
    output logic [N-1:0]        resp_valid,
    output logic                resp_we,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                grant_err,
    output logic [7:0]          err_cnt
);

    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int DEPTH = 2 ** ADDR_W;

    // Same shape as bank_pkg::bank_req_t, sized by this instance's parameters
    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic              valid;
    } s1_req_t;

    logic [IDX_W-1:0] enc_idx;
    logic             enc_any;
    logic             enc_multi;

    s1_req_t           s1_d, s1_q;
    logic              grant_err_d, grant_err_q;
    logic [7:0]        err_cnt_d, err_cnt_q;
    logic [N-1:0]      resp_valid_d, resp_valid_q;
    logic              resp_we_d, resp_we_q;
    logic [DATA_W-1:0] resp_rdata_d, resp_rdata_q;
    logic [DATA_W-1:0] mem_d [DEPTH];
    logic [DATA_W-1:0] mem_q [DEPTH];

    onehot_enc #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_onehot_enc (
        .onehot (grant),
        .idx    (enc_idx),
        .any    (enc_any),
        .multi  (enc_multi)
    );

    // Stage 1: capture the granted requester's fields; a multi-hot grant becomes a bubble
    always_comb begin
        s1_d.idx   = enc_idx;
        s1_d.we    = 1'b0;
        s1_d.addr  = '0;
        s1_d.wdata = '0;
        s1_d.valid = enc_any && !enc_multi;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                s1_d.we    = req_we[i];
                s1_d.addr  = req_addr[i*ADDR_W +: ADDR_W];
                s1_d.wdata = req_wdata[i*DATA_W +: DATA_W];
            end
        end
        grant_err_d = enc_multi;
        err_cnt_d   = err_cnt_q;
        if (enc_multi && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    // Stage 2: memory access; write responses leave resp_rdata untouched
    always_comb begin
        for (int w = 0; w < DEPTH; w++) mem_d[w] = mem_q[w];
        resp_valid_d = '0;
        resp_we_d    = 1'b0;
        resp_rdata_d = resp_rdata_q;
        if (s1_q.valid) begin
            resp_valid_d[s1_q.idx] = 1'b1;
            if (s1_q.we) begin
                mem_d[s1_q.addr] = s1_q.wdata;
                resp_we_d        = 1'b1;
            end else begin
                resp_rdata_d = mem_q[s1_q.addr];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q         <= '0;
            grant_err_q  <= 1'b0;
            err_cnt_q    <= 8'd0;
            resp_valid_q <= '0;
            resp_we_q    <= 1'b0;
            resp_rdata_q <= '0;
            for (int w = 0; w < DEPTH; w++) mem_q[w] <= '0;
        end else begin
            s1_q         <= s1_d;
            grant_err_q  <= grant_err_d;
            err_cnt_q    <= err_cnt_d;
            resp_valid_q <= resp_valid_d;
            resp_we_q    <= resp_we_d;
            resp_rdata_q <= resp_rdata_d;
            for (int w = 0; w < DEPTH; w++) mem_q[w] <= mem_d[w];
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_we    = resp_we_q;
    assign resp_rdata = resp_rdata_q;
    assign grant_err  = grant_err_q;
    assign err_cnt    = err_cnt_q;

endmodule
